// File: rtl/phase_scan_ctrl.sv
// Automatic sampling-phase selector: scans every downsampler phase, counts BER
// checker symbol errors per phase and locks onto the phase with the fewest errors.
module phase_scan_ctrl #(
  parameter int OV_SAMP      = 4,
  parameter int NB_PHASE     = 2,
  parameter int NB_CNT       = 16,
  parameter int SETTLE_SYMB  = 16,
  parameter int WINDOW       = 1024,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic                i_lock,
  input  logic                i_err,
  output logic [NB_PHASE-1:0] o_phase,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_CNT-1:0]   o_best_err
);

  localparam int NB_SET = $clog2(LOCK_TIMEOUT + 1);
  localparam int NB_WIN = $clog2(WINDOW + 1);
  localparam logic [NB_CNT-1:0]   CNT_MAX    = {NB_CNT{1'b1}};
  localparam logic [NB_SET-1:0]   SETTLE_MIN = NB_SET'(SETTLE_SYMB);
  localparam logic [NB_SET-1:0]   TIMEOUT    = NB_SET'(LOCK_TIMEOUT);
  localparam logic [NB_WIN-1:0]   WIN_LEN    = NB_WIN'(WINDOW);
  localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(OV_SAMP - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_STORE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [NB_PHASE-1:0] phase_r, phase_s;
  logic [NB_PHASE-1:0] best_phase_r, best_phase_s;
  logic [NB_CNT-1:0]   best_err_r, best_err_s;
  logic [NB_CNT-1:0]   err_cnt_r, err_cnt_s;
  logic [NB_SET-1:0]   settle_cnt_r, settle_cnt_s;
  logic [NB_WIN-1:0]   win_cnt_r, win_cnt_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic [NB_SET-1:0]   settle_inc_s;
  logic [NB_WIN-1:0]   win_inc_s;
  logic                better_s;

  // Saturating error increment: the count sticks at all ones instead of wrapping.
  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] cnt, input logic hit);
    logic [NB_CNT-1:0] res;
    if (hit && (cnt != CNT_MAX)) begin
      res = cnt + NB_CNT'(1'b1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  assign settle_inc_s = settle_cnt_r + NB_SET'(1'b1);
  assign win_inc_s    = win_cnt_r + NB_WIN'(1'b1);
  assign better_s     = (err_cnt_r < best_err_r);

  assign o_phase    = phase_r;
  assign o_busy     = busy_r;
  assign o_done     = done_r;
  assign o_best_err = best_err_r;

  // State and datapath registers.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r      <= ST_IDLE;
      phase_r      <= {NB_PHASE{1'b0}};
      best_phase_r <= {NB_PHASE{1'b0}};
      best_err_r   <= CNT_MAX;
      err_cnt_r    <= {NB_CNT{1'b0}};
      settle_cnt_r <= {NB_SET{1'b0}};
      win_cnt_r    <= {NB_WIN{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      phase_r      <= phase_s;
      best_phase_r <= best_phase_s;
      best_err_r   <= best_err_s;
      err_cnt_r    <= err_cnt_s;
      settle_cnt_r <= settle_cnt_s;
      win_cnt_r    <= win_cnt_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  // Next-state and next-output logic for the scan sequencer.
  always_comb begin
    state_s      = state_r;
    phase_s      = phase_r;
    best_phase_s = best_phase_r;
    best_err_s   = best_err_r;
    err_cnt_s    = err_cnt_r;
    settle_cnt_s = settle_cnt_r;
    win_cnt_s    = win_cnt_r;
    busy_s       = busy_r;
    done_s       = done_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_s      = ST_SETTLE;
          phase_s      = {NB_PHASE{1'b0}};
          best_phase_s = {NB_PHASE{1'b0}};
          best_err_s   = CNT_MAX;
          err_cnt_s    = {NB_CNT{1'b0}};
          settle_cnt_s = {NB_SET{1'b0}};
          win_cnt_s    = {NB_WIN{1'b0}};
          busy_s       = 1'b1;
          done_s       = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (i_valid) begin
          if ((settle_inc_s >= SETTLE_MIN) && i_lock) begin
            state_s      = ST_MEASURE;
            settle_cnt_s = {NB_SET{1'b0}};
            win_cnt_s    = {NB_WIN{1'b0}};
            err_cnt_s    = {NB_CNT{1'b0}};
          end else if (settle_inc_s == TIMEOUT) begin
            // Checker never locked on this phase: rank it as worst possible.
            state_s      = ST_STORE;
            settle_cnt_s = settle_inc_s;
            err_cnt_s    = CNT_MAX;
          end else begin
            settle_cnt_s = settle_inc_s;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_MEASURE: begin
        if (i_valid) begin
          err_cnt_s = sat_inc(err_cnt_r, i_err);
          win_cnt_s = win_inc_s;
          if (win_inc_s == WIN_LEN) begin
            state_s = ST_STORE;
          end else begin
            state_s = ST_MEASURE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_STORE: begin
        if (better_s) begin
          best_err_s   = err_cnt_r;
          best_phase_s = phase_r;
        end else begin
          best_err_s   = best_err_r;
          best_phase_s = best_phase_r;
        end
        if (phase_r != PHASE_LAST) begin
          state_s      = ST_SETTLE;
          phase_s      = phase_r + NB_PHASE'(1'b1);
          err_cnt_s    = {NB_CNT{1'b0}};
          settle_cnt_s = {NB_SET{1'b0}};
          win_cnt_s    = {NB_WIN{1'b0}};
        end else begin
          state_s = ST_DONE;
          phase_s = better_s ? phase_r : best_phase_r;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_phase_scan_ctrl.sv
// Bench for phase_scan_ctrl: randomized strobe streams scored by a strobe-level
// reference model, run on a 16-bit and a 4-bit (saturating) counter instance.
module tb_phase_scan_ctrl;
  localparam int S  = 4;
  localparam int W  = 16;
  localparam int TO = 32;

  logic        clock = 1'b0;
  logic        i_reset, i_start, i_valid, i_lock, i_err;
  logic [1:0]  ph_a, ph_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] best_a;
  logic [3:0]  best_b;

  int total = 0;
  int bad   = 0;
  bit q_err[$];
  bit q_lock[$];
  int exp_ph[$];
  int perr[4];
  int n_str;

  always #5 clock = ~clock;

  phase_scan_ctrl #(.OV_SAMP(4), .NB_PHASE(2), .NB_CNT(16), .SETTLE_SYMB(S),
                    .WINDOW(W), .LOCK_TIMEOUT(TO)) dut_a (
    .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid),
    .i_lock(i_lock), .i_err(i_err), .o_phase(ph_a), .o_busy(busy_a),
    .o_done(done_a), .o_best_err(best_a));

  phase_scan_ctrl #(.OV_SAMP(4), .NB_PHASE(2), .NB_CNT(4), .SETTLE_SYMB(S),
                    .WINDOW(W), .LOCK_TIMEOUT(TO)) dut_b (
    .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid),
    .i_lock(i_lock), .i_err(i_err), .o_phase(ph_b), .o_busy(busy_b),
    .o_done(done_b), .o_best_err(best_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit noisy(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  function automatic int sat(input int v, input int nb);
    int mx;
    mx = (1 << nb) - 1;
    if (v < 0 || v > mx) return mx;
    return v;
  endfunction

  // Stream builder: per phase a settle run (optionally never locking) then W measured strobes.
  task automatic build(input int nerr[4], input bit ok[4], input int noise);
    int r, sl, need;
    bit e;
    q_err.delete();
    q_lock.delete();
    for (int p = 0; p < 4; p++) begin
      if (ok[p]) begin
        r  = int'($urandom_range(0, 6));
        sl = (r + 1 > S) ? r + 1 : S;
        for (int k = 1; k <= sl; k++) begin
          q_lock.push_back(k > r);
          q_err.push_back(noisy(noise));
        end
        need = nerr[p];
        for (int i = 0; i < W; i++) begin
          e = int'($urandom_range(0, W - 1 - i)) < need;
          if (e) need--;
          q_err.push_back(e);
          q_lock.push_back(bit'($urandom_range(0, 1)));
        end
      end else begin
        for (int k = 1; k <= TO; k++) begin
          q_lock.push_back(1'b0);
          q_err.push_back(noisy(noise));
        end
      end
    end
  endtask

  // Reference model: walks the strobe stream using the scan rules; -1 marks a lock timeout.
  task automatic run_model();
    int idx, cnt;
    bit reached;
    idx = 0;
    exp_ph.delete();
    for (int p = 0; p < 4; p++) begin
      reached = 1'b0;
      cnt = 0;
      for (int k = 1; k <= TO; k++) begin
        exp_ph.push_back(p);
        idx++;
        if (k >= S && q_lock[idx-1]) begin
          reached = 1'b1;
          break;
        end
      end
      if (reached) begin
        for (int w = 0; w < W; w++) begin
          exp_ph.push_back(p);
          cnt += int'(q_err[idx]);
          idx++;
        end
        perr[p] = cnt;
      end else begin
        perr[p] = -1;
      end
    end
    n_str = idx;
  endtask

  task automatic expect_best(input int nb, output int ph, output int be);
    be = (1 << nb) - 1;
    ph = 0;
    for (int p = 0; p < 4; p++) begin
      if (sat(perr[p], nb) < be) begin
        be = sat(perr[p], nb);
        ph = p;
      end
    end
  endtask

  task automatic start_scan();
    @(negedge clock);
    i_start = 1'b1;
    @(negedge clock);
    i_start = 1'b0;
    chk("start_busy", 32'(busy_a), 32'd1);
    chk("start_done", 32'(done_a), 32'd0);
    chk("start_phase", 32'(ph_a), 32'd0);
    chk("start_best", 32'(best_a), 32'hFFFF);
  endtask

  task automatic feed(input int n_lim, input int start_at);
    for (int i = 0; i < n_lim; i++) begin
      @(negedge clock);
      chk("strobe_phase_a", 32'(ph_a), 32'(exp_ph[i]));
      chk("strobe_phase_b", 32'(ph_b), 32'(exp_ph[i]));
      chk("strobe_busy", 32'(busy_a), 32'd1);
      i_valid = 1'b1;
      i_err   = q_err[i];
      i_lock  = q_lock[i];
      @(negedge clock);
      i_valid = 1'b0;
      i_err   = 1'($urandom_range(0, 1));
      i_lock  = 1'($urandom_range(0, 1));
      if (i == start_at) i_start = 1'b1;
      @(negedge clock);
      i_start = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic check_result(input string tag);
    int pa, ea, pb, eb;
    expect_best(16, pa, ea);
    expect_best(4, pb, eb);
    for (int rep = 0; rep < 2; rep++) begin
      chk({tag, "_done"}, 32'(done_a), 32'd1);
      chk({tag, "_busy"}, 32'(busy_a), 32'd0);
      chk({tag, "_phase_a"}, 32'(ph_a), 32'(pa));
      chk({tag, "_best_a"}, 32'(best_a), 32'(ea));
      chk({tag, "_phase_b"}, 32'(ph_b), 32'(pb));
      chk({tag, "_best_b"}, 32'(best_b), 32'(eb));
      chk({tag, "_done_b"}, 32'(done_b), 32'd1);
      for (int c = 0; c < 6; c++) begin
        @(negedge clock);
        i_valid = 1'($urandom_range(0, 1));
        i_err   = 1'($urandom_range(0, 1));
        i_lock  = 1'($urandom_range(0, 1));
      end
      i_valid = 1'b0;
    end
  endtask

  task automatic run_scan(input string tag, input int nerr[4], input bit ok[4],
                          input int noise, input bit pulse);
    int sa;
    build(nerr, ok, noise);
    run_model();
    sa = -1;
    if (pulse) begin
      for (int i = 0; i < n_str; i++) begin
        if (exp_ph[i] == 1 && sa < 0) sa = i + 8;
      end
    end
    start_scan();
    feed(n_str, sa);
    check_result(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, 32'(ph_a), 32'd0);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_done"}, 32'(done_a), 32'd0);
    chk({tag, "_best_a"}, 32'(best_a), 32'hFFFF);
    chk({tag, "_best_b"}, 32'(best_b), 32'hF);
  endtask

  initial begin
    int ne[4];
    bit ok[4];
    i_reset = 1'b1;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_lock  = 1'b0;
    i_err   = 1'b0;
    #2 i_reset = 1'b0;
    #1 chk_reset_vals("por");
    i_start = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_vals("por_hold");
    i_start = 1'b0;
    i_reset = 1'b1;

    run_scan("errs_5037", '{5, 0, 3, 7}, '{1'b1, 1'b1, 1'b1, 1'b1}, 0, 1'b0);
    run_scan("tie", '{2, 2, 2, 2}, '{1'b1, 1'b1, 1'b1, 1'b1}, 50, 1'b0);
    run_scan("no_lock", '{4, 6, 0, 1}, '{1'b1, 1'b1, 1'b0, 1'b1}, 30, 1'b0);
    run_scan("saturate", '{16, 16, 16, 16}, '{1'b1, 1'b1, 1'b1, 1'b1}, 100, 1'b0);
    run_scan("start_ignored", '{3, 9, 1, 1}, '{1'b1, 1'b1, 1'b1, 1'b1}, 20, 1'b1);

    // Abort a second scan halfway with a reset asserted between clock edges.
    build('{1, 2, 3, 4}, '{1'b1, 1'b1, 1'b1, 1'b1}, 20);
    run_model();
    start_scan();
    feed(n_str / 2, -1);
    @(posedge clock);
    #2 i_reset = 1'b0;
    #1 chk_reset_vals("mid_reset");
    i_start = 1'b1;
    repeat (3) @(posedge clock);
    #1 chk_reset_vals("mid_reset_hold");
    @(negedge clock);
    i_start = 1'b0;
    i_reset = 1'b1;

    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 4; p++) begin
        ne[p] = int'($urandom_range(0, W));
        ok[p] = ($urandom_range(0, 4) != 0);
      end
      run_scan("random", ne, ok, int'($urandom_range(0, 100)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
